mesh_task_ctrl: RTL



---
 rtl/mesh_task_ctrl_if.sv | 28 ++
 rtl/mesh_task_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mesh_task_ctrl_if.sv
// Software-side control/status bus of the mesh task sequencer: register
// port plus run control and run status.
interface mesh_task_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             cfg_we;
    logic [3:0]       cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    // Software / host side
    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, abort,
        input  cfg_rdata, busy, done, timeout, cycle_count
    );

    // Sequencer side
    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, abort,
        output cfg_rdata, busy, done, timeout, cycle_count
    );
endinterface

// File: rtl/mesh_task_ctrl.sv
// Mesh task sequencer: holds per-PE traffic config, flushes the PEs,
// runs them until every enabled PE reports send+receive finish (or the
// run times out / is aborted) and reports status with a cycle count.
module mesh_task_ctrl #(
    parameter int unsigned FLUSH_CYCLES   = 4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic           clk,
    input  logic           rst,
    mesh_task_ctrl_if.slave bus,
    output logic [7:0]     pe_enable,
    output logic [7:0]     pe_dbg_mode_wire,
    output logic [23:0]    pe_send_num_wire,
    output logic [23:0]    pe_receive_num_wire,
    output logic [31:0]    pe_rate_wire,
    output logic [191:0]   pe_dst_seq_wire,
    output logic [31:0]    pe_mode_wire,
    output logic [7:0]     pe_flush_wire,
    input  logic [7:0]     pe_task_receive_finish_flag,
    input  logic [7:0]     pe_task_send_finish_flag
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_END   = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [7:0]         tx_q, tx_d, rx_q, rx_d;
    logic               done_q, done_d, timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic [7:0]         pe_enable_q, pe_enable_d;
    logic [7:0]         pe_flush_q, pe_flush_d;

    logic [7:0]         en_q, en_d, dbg_q, dbg_d;
    logic [23:0]        send_num_q, send_num_d, recv_num_q, recv_num_d;
    logic [31:0]        rate_q, rate_d, mode_q, mode_d;
    logic [191:0]       dst_seq_q, dst_seq_d;

    logic               wr_ok;
    logic               complete;

    // Saturating run counter increment and completion test on the
    // registered stickies (masked stickies are always a subset of en).
    always_comb begin
        cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        complete = ((tx_q & rx_q) == en_q);
        wr_ok    = bus.cfg_we && (state_q == ST_IDLE || state_q == ST_END);
    end

    // Next-state logic: config writes, run FSM, stickies and status.
    always_comb begin
        en_d        = en_q;
        dbg_d       = dbg_q;
        send_num_d  = send_num_q;
        recv_num_d  = recv_num_q;
        rate_d      = rate_q;
        mode_d      = mode_q;
        dst_seq_d   = dst_seq_q;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        done_d      = done_q;
        timeout_d   = timeout_q;

        // Config is frozen while the mesh is being flushed or run.
        if (wr_ok) begin
            case (bus.cfg_addr)
                4'd0:    {dbg_d, en_d} = bus.cfg_wdata[15:0];
                4'd1:    send_num_d    = bus.cfg_wdata[23:0];
                4'd2:    recv_num_d    = bus.cfg_wdata[23:0];
                4'd3:    rate_d        = bus.cfg_wdata;
                4'd4:    mode_d        = bus.cfg_wdata;
                default: begin
                    for (int k = 0; k < 6; k++) begin
                        if (bus.cfg_addr == 4'(k + 5))
                            dst_seq_d[k*32 +: 32] = bus.cfg_wdata;
                    end
                end
            endcase
        end

        case (state_q)
            ST_IDLE, ST_END: begin
                if (bus.start) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                    cnt_d       = '0;
                    tx_d        = '0;
                    rx_d        = '0;
                    done_d      = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (bus.abort)
                    state_d = ST_IDLE;
                else if (flush_cnt_q == FLUSH_LAST)
                    state_d = ST_RUN;
                else
                    flush_cnt_d = flush_cnt_q + 4'd1;
            end
            ST_RUN: begin
                // Abort freezes count and stickies as they were.
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    tx_d  = tx_q | (pe_task_send_finish_flag & en_q);
                    rx_d  = rx_q | (pe_task_receive_finish_flag & en_q);
                    if (complete) begin
                        state_d = ST_END;
                        done_d  = 1'b1;
                    end else if (64'(cnt_inc) >= 64'(TIMEOUT_CYCLES)) begin
                        state_d   = ST_END;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered outputs follow the next state.
        busy_d      = (state_d == ST_FLUSH) || (state_d == ST_RUN);
        pe_enable_d = (state_d == ST_RUN)   ? en_d  : 8'h00;
        pe_flush_d  = (state_d == ST_FLUSH) ? 8'hFF : 8'h00;
    end

    // State and config registers; synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            cnt_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            pe_enable_q <= '0;
            pe_flush_q  <= '0;
            en_q        <= '0;
            dbg_q       <= '0;
            send_num_q  <= '0;
            recv_num_q  <= '0;
            rate_q      <= '0;
            mode_q      <= '0;
            dst_seq_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            pe_enable_q <= pe_enable_d;
            pe_flush_q  <= pe_flush_d;
            en_q        <= en_d;
            dbg_q       <= dbg_d;
            send_num_q  <= send_num_d;
            recv_num_q  <= recv_num_d;
            rate_q      <= rate_d;
            mode_q      <= mode_d;
            dst_seq_q   <= dst_seq_d;
        end
    end

    // Combinational register readback; unmapped addresses read zero.
    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            4'd0:    bus.cfg_rdata = {16'b0, dbg_q, en_q};
            4'd1:    bus.cfg_rdata = {8'b0, send_num_q};
            4'd2:    bus.cfg_rdata = {8'b0, recv_num_q};
            4'd3:    bus.cfg_rdata = rate_q;
            4'd4:    bus.cfg_rdata = mode_q;
            4'd5:    bus.cfg_rdata = dst_seq_q[31:0];
            4'd6:    bus.cfg_rdata = dst_seq_q[63:32];
            4'd7:    bus.cfg_rdata = dst_seq_q[95:64];
            4'd8:    bus.cfg_rdata = dst_seq_q[127:96];
            4'd9:    bus.cfg_rdata = dst_seq_q[159:128];
            4'd10:   bus.cfg_rdata = dst_seq_q[191:160];
            4'd11:   bus.cfg_rdata = {29'b0, timeout_q, done_q, busy_q};
            4'd12:   bus.cfg_rdata = 32'(cnt_q);
            4'd13:   bus.cfg_rdata = {16'b0, rx_q, tx_q};
            default: bus.cfg_rdata = '0;
        endcase
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.timeout         = timeout_q;
    assign bus.cycle_count     = cnt_q;

    assign pe_enable           = pe_enable_q;
    assign pe_flush_wire       = pe_flush_q;
    assign pe_dbg_mode_wire    = dbg_q;
    assign pe_send_num_wire    = send_num_q;
    assign pe_receive_num_wire = recv_num_q;
    assign pe_rate_wire        = rate_q;
    assign pe_mode_wire        = mode_q;
    assign pe_dst_seq_wire     = dst_seq_q;

endmodule
